// File: rtl/alu_exec_unit.sv
// EX-stage ALU: registered single-cycle results/flags plus an optional iterative
// shift-add multiplier writing hi/lo (built only when ALU_MULT_EN is defined).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             halt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             is_break;
  logic             accept;

  // Handshake: a request is taken on a rising edge when in_valid is high while
  // the unit is idle (busy low) and not halted; anything else is dropped, never queued.
  assign accept    = in_valid && (state == IDLE) && !halt;
  assign is_break  = (control == 4'b1111);
  assign sum       = a + b;
  assign diff      = a - b;
  assign dbg_state = state;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011: alu_res = a ^ b;
      4'b0100: alu_res = sum;
      4'b0101: alu_res = diff;
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1010: alu_res = b << (WIDTH/2);
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1100, 4'b1101: alu_res = sum;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               neg_prod;
  logic               is_mult;
  logic               signed_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     acc;

  assign is_mult   = (control == 4'b1000) || (control == 4'b1001);
  assign signed_op = (control == 4'b1000);
  // Negating the most-negative value wraps to itself, which is its correct unsigned magnitude.
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  // Upper half accumulates the multiplicand; the multiplier shifts out of the low half.
  assign acc       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
`else
  assign busy = 1'b0;
  assign hi   = '0;
  assign lo   = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      halt     <= 1'b0;
`ifdef ALU_MULT_EN
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      prod     <= '0;
      cnt      <= '0;
      neg_prod <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_break) begin
              halt <= 1'b1;
              done <= 1'b1;
            end
`ifdef ALU_MULT_EN
            else if (is_mult) begin
              busy     <= 1'b1;
              state    <= MUL;
              mcand    <= mag_a;
              prod     <= {{WIDTH{1'b0}}, mag_b};
              cnt      <= '0;
              neg_prod <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            end
`endif
            else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              overflow <= alu_ovf;
              done     <= 1'b1;
            end
          end
        end
`ifdef ALU_MULT_EN
        MUL: begin
          prod <= {acc, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          {hi, lo} <= neg_prod ? -prod : prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised + directed bench for alu_exec_unit; a 64-bit arithmetic reference
// model provides every expected value. Multiply checks follow ALU_MULT_EN.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [3:0]   control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         halt;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;
  logic [3:0]   codes[13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                              4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

  alu_exec_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .control(control),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .hi(hi), .lo(lo), .halt(halt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [3:0] c, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] r,
                                output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    s  = 0;
    ov = 1'b0;
    r  = '0;
    case (c)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin s = sa + sb; r = s[W-1:0]; ov = (s != longint'($signed(s[W-1:0]))); end
      4'd3: r = x ^ y;
      4'd4: r = x + y;
      4'd5: r = x - y;
      4'd6: begin s = sa - sb; r = s[W-1:0]; ov = (s != longint'($signed(s[W-1:0]))); end
      4'd7: r = (sa < sb) ? 1 : 0;
      4'd10: r = y * 32'd65536;
      4'd11: r = (x < y) ? 1 : 0;
      4'd12, 4'd13: r = x + y;
      default: r = '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    control  = c;
    a        = x;
    b        = y;
    in_valid = 1'b1;
  endtask

  // One single-cycle op; checks done, result, zero and overflow one edge after acceptance.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    logic [W-1:0] r;
    logic ov;
    drive(c, x, y);
    model(c, x, y, r, ov);
    exp_q.push_back(r);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check({tag, "_done"}, done, 1);
    r = exp_q.pop_front();
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, zero, (r == '0));
    check({tag, "_ovf"}, overflow, ov);
    last_res = r;
  endtask

`ifdef ALU_MULT_EN
  // Starts a multiply; optionally holds an ADD 1+1 request for the whole busy period.
  task automatic run_mult(input string tag, input logic [3:0] c, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit hold_add);
    logic [63:0] p;
    int n, busy_cycles, dones;
    if (c == 4'd8) p = longint'($signed(x)) * longint'($signed(y));
    else           p = {32'b0, x} * {32'b0, y};
    drive(c, x, y);
    @(posedge clock);
    #1;
    check({tag, "_busy_start"}, busy, 1);
    if (hold_add) begin
      control = 4'd2; a = 1; b = 1;
    end else begin
      in_valid = 1'b0;
    end
    busy_cycles = 1;
    dones = 0;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (done) dones++;
      if (busy) busy_cycles++;
    end
    check({tag, "_timeout"}, busy, 0);
    check({tag, "_busy_len"}, busy_cycles, W + 1);
    check({tag, "_done_cnt"}, dones, 1);
    check({tag, "_hi"}, hi, p[63:32]);
    check({tag, "_lo"}, lo, p[31:0]);
    check({tag, "_res_kept"}, result, last_res);
    if (hold_add) begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      check({tag, "_add_after_done"}, done, 1);
      check({tag, "_add_after_res"}, result, 2);
      last_res = 2;
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] r;
    logic ov;
    reset = 1'b1; in_valid = 1'b0; control = '0; a = '0; b = '0;
    last_res = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", overflow, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_halt", halt, 0);
    @(negedge clock);
    reset = 1'b0;

    // directed corner cases
    do_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1);
    @(posedge clock); #1;
    check("add_ovf_done_pulse", done, 0);
    do_op("subu_eq", 4'd5, 32'd5, 32'd5);
    do_op("sltu", 4'd11, 32'd1, 32'hFFFF_FFFF);
    do_op("slt", 4'd7, 32'd1, 32'hFFFF_FFFF);
    do_op("lui", 4'd10, 32'd0, 32'h0000_1234);
    do_op("sub_ovf", 4'd6, 32'h8000_0000, 32'd1);
    do_op("unused", 4'd14, 32'hDEAD_BEEF, 32'h1234_5678);

    // random single-cycle ops
    for (int i = 0; i < 40; i++)
      do_op("rand", codes[$urandom_range(0, 12)], rnd_operand(), rnd_operand());

    // back-to-back: done must stay high every cycle
    for (int i = 0; i < 8; i++) begin
      logic [3:0] c;
      logic [W-1:0] x, y;
      c = codes[$urandom_range(0, 12)];
      x = rnd_operand();
      y = rnd_operand();
      drive(c, x, y);
      model(c, x, y, r, ov);
      exp_q.push_back(r);
      @(posedge clock);
      #1;
      check("b2b_done", done, 1);
      r = exp_q.pop_front();
      check("b2b_result", result, r);
      check("b2b_ovf", overflow, ov);
      last_res = r;
    end
    in_valid = 1'b0;

`ifdef ALU_MULT_EN
    run_mult("mult_neg", 4'd8, 32'hFFFF_FFFE, 32'd3, 1'b1);
    run_mult("multu", 4'd9, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_mult("mult_minneg", 4'd8, 32'h8000_0000, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 4; i++)
      run_mult("mult_rand", ($urandom_range(0, 1) != 0) ? 4'd8 : 4'd9,
               rnd_operand(), rnd_operand(), 1'b0);
    // reset in the middle of a multiply
    drive(4'd9, 32'hFFFF_FFFE, 32'd3);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midmul_rst_busy", busy, 0);
    check("midmul_rst_hi", hi, 0);
    check("midmul_rst_lo", lo, 0);
    @(negedge clock);
    reset = 1'b0;
    last_res = '0;
    do_op("after_midmul_rst", 4'd2, 32'd2, 32'd3);
`else
    do_op("mult_off", 4'd8, 32'd2, 32'd3);
    check("mult_off_busy", busy, 0);
    check("mult_off_hi", hi, 0);
    check("mult_off_lo", lo, 0);
    do_op("multu_off", 4'd9, 32'hFFFF_FFFE, 32'd3);
    check("multu_off_busy", busy, 0);
`endif

    // BREAK halts; later requests are dropped until reset
    drive(4'd15, 32'd7, 32'd9);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("break_done", done, 1);
    check("break_halt", halt, 1);
    check("break_res_kept", result, last_res);
    drive(4'd2, 32'd1, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("halted_no_done", done, 0);
    check("halted_res_kept", result, last_res);
    check("halted_sticky", halt, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("halt_cleared", halt, 0);
    check("halt_rst_result", result, 0);
    @(negedge clock);
    reset = 1'b0;
    do_op("after_halt_add", 4'd2, 32'd1, 32'd1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
